// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pkg
// Brief    : Shared Hamming(7,4) types, codeword position map and encoder.
// Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int c_data_w = 4;
    localparam int c_code_w = 7;

    // Codeword positions are 1-based; bit (pos-1) of the word holds position pos.
    localparam int c_pos_p1 = 1;
    localparam int c_pos_p2 = 2;
    localparam int c_pos_d1 = 3;
    localparam int c_pos_p3 = 4;
    localparam int c_pos_d2 = 5;
    localparam int c_pos_d3 = 6;
    localparam int c_pos_d4 = 7;

    function automatic logic [c_code_w-1:0] hamming_encode(input logic [c_data_w-1:0] d);
        logic [c_code_w-1:0] c;
        c               = '0;
        c[c_pos_d1-1]   = d[0];
        c[c_pos_d2-1]   = d[1];
        c[c_pos_d3-1]   = d[2];
        c[c_pos_d4-1]   = d[3];
        c[c_pos_p1-1]   = d[0] ^ d[1] ^ d[3];
        c[c_pos_p2-1]   = d[0] ^ d[2] ^ d[3];
        c[c_pos_p3-1]   = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_enc.sv
`default_nettype none
// ============================================================================
// Module   : hamming_enc
// Brief    : Combinational Hamming(7,4) encoder, nibble to codeword.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_enc
    import hamming_pkg::*;
(
    input  logic [c_data_w-1:0] data,
    output logic [c_code_w-1:0] code
);

    assign code = hamming_encode(data);

endmodule
`default_nettype wire

// File: rtl/hamming_tx.sv
`default_nettype none
// ============================================================================
// Module   : hamming_tx
// Brief    : Hamming(7,4) transmitter: encode, optional error injection,
//            start/stop framed serialisation on a single line.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_tx
    import hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_data_w-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          err_pos,
    output logic                tx_line,
    output logic                busy,
    output logic [c_code_w-1:0] code_out,
    output logic                done
);

    localparam int                  c_baud_w       = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [c_baud_w-1:0] c_baud_last    = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_prelast = (CLKS_PER_BIT > 1) ? c_baud_w'(CLKS_PER_BIT - 2) : '0;
    localparam logic                c_single       = (CLKS_PER_BIT == 1);
    localparam logic [2:0]          c_bit_last     = 3'd6;

    tx_state_t           r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]          r_bit;
    logic [c_code_w-1:0] r_shift;
    logic [c_code_w-1:0] r_code;
    logic                r_tx;
    logic                r_done;

    logic [c_code_w-1:0] w_encoded;
    logic [c_code_w-1:0] w_inject;
    logic [c_code_w-1:0] w_code;
    logic                w_accept;
    logic                w_baud_end;

    hamming_enc u_enc (
        .data (in_data),
        .code (w_encoded)
    );

    assign w_inject   = (err_pos == 3'd0) ? '0 : (c_code_w'(1) << (err_pos - 3'd1));
    assign w_code     = w_encoded ^ w_inject;
    assign in_ready   = (r_state == IDLE) && !rst;
    assign busy       = (r_state != IDLE);
    assign w_accept   = in_valid && in_ready;
    assign w_baud_end = (r_baud == c_baud_last);

    assign tx_line  = r_tx;
    assign code_out = r_code;
    assign done     = r_done;

    // done is registered, so it is raised on the edge entering the final stop cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_code  <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= START;
                        r_code  <= w_code;
                        r_shift <= w_code;
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                        r_bit   <= '0;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[c_code_w-1:1]};
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == c_bit_last) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                            r_done  <= c_single;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[c_code_w-1:1]};
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        r_done <= (r_baud == c_baud_prelast);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
